// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmitter, one frame per accepted request.
//
// Frame on the line: start (0), DATA_BITS data bits LSB first, optional even
// parity bit, then a stop level (1) lasting SB_TICKS baud ticks. Start, data
// and parity bits each last OVERSAMPLE ticks of the shared 16x baud tick.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// (XOR of the byte latched at acceptance) between the last data bit and stop.
// With the macro undefined the PARITY state and parity logic do not exist.
//
// Handshake: i_tx_start is a request that is only looked at in IDLE. When it
// is high at an edge in IDLE the byte on i_data is taken at that same edge and
// o_busy rises; requests while busy are dropped, not queued. o_tx_done pulses
// for one clk at the edge the stop bit completes, the same edge o_busy falls.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   i_baud_rate  oversampling tick (single-clk pulse, or held high)
//   i_tx_start   transmit request, sampled in IDLE only
//   i_data       byte to send, captured on acceptance
//   o_tx         registered serial line, idles high
//   o_tx_done    one-clk pulse at end of stop bit
//   o_busy       high from acceptance until return to IDLE
//   dbg_state    current FSM state, for observation only
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICKS   = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_baud_rate,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx,
    output logic                 o_tx_done,
    output logic                 o_busy,
    output logic [2:0]           dbg_state
);

    // The tick counter must reach the longer of a data bit and the stop bit.
    localparam int MAX_TICKS = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] OS_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SB_LAST  = CW'(SB_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte at acceptance, so later shifting of
    // shreg cannot disturb it.
    logic par_bit;
`endif

    assign shreg_next = shreg >> 1;
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
            o_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            o_tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_tx <= 1'b1;
                    // Acceptance is immediate; the start bit begins at this
                    // edge rather than at the next baud tick.
                    if (i_tx_start) begin
                        shreg    <= i_data;
                        tick_cnt <= '0;
                        state    <= START;
                        o_tx     <= 1'b0;
                        o_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        par_bit  <= ^i_data;
`endif
                    end
                end

                START: begin
                    if (i_baud_rate) begin
                        if (tick_cnt == OS_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= DATA;
                            o_tx     <= shreg[0];
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (i_baud_rate) begin
                        if (tick_cnt == OS_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= shreg_next;
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
                                o_tx  <= par_bit;
`else
                                state <= STOP;
                                o_tx  <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                o_tx    <= shreg_next[0];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (i_baud_rate) begin
                        if (tick_cnt == OS_LAST) begin
                            tick_cnt <= '0;
                            state    <= STOP;
                            o_tx     <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif

                STOP: begin
                    o_tx <= 1'b1;
                    if (i_baud_rate) begin
                        if (tick_cnt == SB_LAST) begin
                            tick_cnt  <= '0;
                            state     <= IDLE;
                            o_tx_done <= 1'b1;
                            o_busy    <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- directed bench for uart_tx with default parameters.
// Expected line levels come from a per-frame bit list (exp_q) built from the
// byte being sent; every clk after acceptance the line, busy and done are
// compared against it. Compile with +define+UART_TX_PARITY_EN to cover the
// parity build.
// -----------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 176;
`else
    localparam int FRAME = 160;
`endif

    logic       clk;
    logic       rst;
    logic       i_baud_rate;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tx_done;
    logic       o_busy;
    logic [2:0] dbg_state;

    int total;
    int bad;

    logic exp_q[$];

    uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .i_baud_rate(i_baud_rate),
        .i_tx_start (i_tx_start),
        .i_data     (i_data),
        .o_tx       (o_tx),
        .o_tx_done  (o_tx_done),
        .o_busy     (o_busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard model ----------------
    // Expected line level per bit slot: start, data LSB first, [parity], stop.
    task automatic build_frame(input logic [7:0] d);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    // Line level k clks after the accept edge, with one tick every p clks.
    function automatic logic exp_line(input int k, input int p);
        int idx;
        idx = k / (16 * p);
        if (idx < exp_q.size()) return exp_q[idx];
        return 1'b1;
    endfunction

    // ---------------- drivers ----------------
    // Returns at the negedge right after the accept edge (k = 0).
    task automatic send_req(input logic [7:0] d);
        @(negedge clk);
        i_data     = d;
        i_tx_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst         = 1'b0;
        i_tx_start  = 1'b1;
        i_baud_rate = 1'b1;
        i_data      = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done !== 1'b0) begin
                bad++;
                $display("FAIL reset c=%0d tx=%b busy=%b done=%b want 1/0/0", c, o_tx, o_busy, o_tx_done);
            end
        end
        rst        = 1'b1;
        i_tx_start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle c=%0d tx=%b busy=%b done=%b want 1/0/0", c, o_tx, o_busy, o_tx_done);
            end
        end
    endtask

    task automatic test_single();
        build_frame(8'hA5);
        i_baud_rate = 1'b1;
        send_req(8'hA5);
        i_tx_start = 1'b0;
        for (int k = 0; k <= FRAME; k++) begin
            total++;
            if (o_tx !== exp_line(k, 1) || o_busy !== (k < FRAME) || o_tx_done !== (k == FRAME)) begin
                bad++;
                $display("FAIL single k=%0d tx=%b busy=%b done=%b want %b/%b/%b",
                         k, o_tx, o_busy, o_tx_done, exp_line(k, 1), k < FRAME, k == FRAME);
            end
            step();
        end
        total++;
        if (o_tx_done !== 1'b0 || o_busy !== 1'b0 || o_tx !== 1'b1) begin
            bad++;
            $display("FAIL single_after tx=%b busy=%b done=%b want 1/0/0", o_tx, o_busy, o_tx_done);
        end
    endtask

    task automatic test_sparse_ticks();
        build_frame(8'h00);
        i_baud_rate = 1'b0;
        send_req(8'h00);
        i_tx_start = 1'b0;
        for (int k = 0; k <= FRAME * 4; k++) begin
            total++;
            if (o_tx !== exp_line(k, 4) || o_busy !== (k < FRAME * 4) || o_tx_done !== (k == FRAME * 4)) begin
                bad++;
                $display("FAIL sparse k=%0d tx=%b busy=%b done=%b want %b/%b/%b",
                         k, o_tx, o_busy, o_tx_done, exp_line(k, 4), k < FRAME * 4, k == FRAME * 4);
            end
            i_baud_rate = ((k + 1) % 4 == 0);
            step();
        end
        i_baud_rate = 1'b1;
    endtask

    task automatic test_start_while_busy();
        build_frame(8'h3C);
        i_baud_rate = 1'b1;
        send_req(8'h3C);
        i_tx_start = 1'b0;
        for (int k = 0; k <= FRAME; k++) begin
            total++;
            if (o_tx !== exp_line(k, 1) || o_busy !== (k < FRAME) || o_tx_done !== (k == FRAME)) begin
                bad++;
                $display("FAIL busy_start k=%0d tx=%b busy=%b done=%b want %b/%b/%b",
                         k, o_tx, o_busy, o_tx_done, exp_line(k, 1), k < FRAME, k == FRAME);
            end
            if (k == 40) begin
                i_tx_start = 1'b1;
                i_data     = 8'hFF;
            end
            if (k == 100) i_tx_start = 1'b0;
            step();
        end
        total++;
        if (o_tx_done !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_after busy=%b done=%b want 0/0", o_busy, o_tx_done);
        end
    endtask

    task automatic test_reset_mid_frame();
        i_baud_rate = 1'b1;
        send_req(8'h50);
        i_tx_start = 1'b0;
        // k = 70 lies inside data bit 3, which is 0 for 0x50.
        for (int k = 0; k < 70; k++) step();
        total++;
        if (o_tx !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_before_rst tx=%b busy=%b want 0/1", o_tx, o_busy);
        end
        rst = 1'b0;
        step();
        total++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst tx=%b busy=%b done=%b want 1/0/0", o_tx, o_busy, o_tx_done);
        end
        rst = 1'b1;
        step();
        total++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_release tx=%b busy=%b done=%b want 1/0/0", o_tx, o_busy, o_tx_done);
        end
        build_frame(8'hC3);
        send_req(8'hC3);
        i_tx_start = 1'b0;
        for (int k = 0; k <= FRAME; k++) begin
            total++;
            if (o_tx !== exp_line(k, 1) || o_busy !== (k < FRAME) || o_tx_done !== (k == FRAME)) begin
                bad++;
                $display("FAIL after_rst k=%0d tx=%b busy=%b done=%b want %b/%b/%b",
                         k, o_tx, o_busy, o_tx_done, exp_line(k, 1), k < FRAME, k == FRAME);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        build_frame(8'h81);
        i_baud_rate = 1'b1;
        send_req(8'h81);
        // Request stays high through the whole first frame.
        for (int k = 0; k <= FRAME; k++) begin
            total++;
            if (o_tx !== exp_line(k, 1) || o_busy !== (k < FRAME) || o_tx_done !== (k == FRAME)) begin
                bad++;
                $display("FAIL b2b_first k=%0d tx=%b busy=%b done=%b want %b/%b/%b",
                         k, o_tx, o_busy, o_tx_done, exp_line(k, 1), k < FRAME, k == FRAME);
            end
            if (k == FRAME) i_data = 8'h42;
            step();
        end
        build_frame(8'h42);
        for (int k = 0; k <= FRAME; k++) begin
            total++;
            if (o_tx !== exp_line(k, 1) || o_busy !== (k < FRAME) || o_tx_done !== (k == FRAME)) begin
                bad++;
                $display("FAIL b2b_second k=%0d tx=%b busy=%b done=%b want %b/%b/%b",
                         k, o_tx, o_busy, o_tx_done, exp_line(k, 1), k < FRAME, k == FRAME);
            end
            if (k == 0) i_tx_start = 1'b0;
            step();
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] vec [2];
        logic       par [2];
        vec[0] = 8'h07; par[0] = 1'b1;
        vec[1] = 8'h03; par[1] = 1'b0;
        i_baud_rate = 1'b1;
        for (int v = 0; v < 2; v++) begin
            build_frame(vec[v]);
            send_req(vec[v]);
            i_tx_start = 1'b0;
            for (int k = 0; k <= FRAME; k++) begin
                total++;
                if (k >= 144 && k < 160) begin
                    if (o_tx !== par[v]) begin
                        bad++;
                        $display("FAIL parity v=%0d k=%0d tx=%b want %b", v, k, o_tx, par[v]);
                    end
                end else if (o_tx !== exp_line(k, 1) || o_tx_done !== (k == FRAME)) begin
                    bad++;
                    $display("FAIL parity_frame v=%0d k=%0d tx=%b done=%b want %b/%b",
                             v, k, o_tx, o_tx_done, exp_line(k, 1), k == FRAME);
                end
                step();
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        i_baud_rate = 1'b0;
        i_tx_start  = 1'b0;
        i_data      = 8'h00;

        test_reset();
        test_single();
        test_sparse_ticks();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter that serializes one byte per request: start bit, data LSB first, optional parity, then stop.
- Pairs with the existing RX block on the same link and runs from the same 16x-oversampling baud tick generator.
- Sits between the user/interface logic that supplies bytes and the serial line.
- Has one output flop driving the line, so the line is glitch-free.

Parameters:
- DATA_BITS, 8, number of data bits per frame (LSB first).
- SB_TICKS, 16, baud ticks per stop bit; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- OVERSAMPLE, 16, baud ticks per start/data/parity bit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge).
- i_baud_rate  in  1  oversampling tick; one-clk pulse, or held high for one tick every clk.
- i_tx_start  in  1  request to send i_data; sampled only in IDLE.
- i_data  in  DATA_BITS  byte to transmit; captured on the accepted start.
- o_tx  out  1  serial line, registered; idles high.
- o_tx_done  out  1  one-clk pulse when the stop bit completes.
- o_busy  out  1  high from start acceptance until the return to IDLE.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE; o_tx=1, o_tx_done=0, o_busy=0.
  - Tick counter, bit counter and shift register cleared.
  - Reset applied mid-frame aborts the frame; o_tx=1 after that edge, with no done pulse.
- FSM states: IDLE, START, DATA, PARITY (only with the feature), STOP.
- IDLE:
  - o_tx=1.
  - If i_tx_start=1 at an edge: latch i_data into the shift register, clear the tick counter, go to START, set o_tx=0 and o_busy=1 at that same edge.
  - Acceptance does not wait for a baud tick.
- START:
  - Each i_baud_rate=1 increments the tick counter (width clog2(max(OVERSAMPLE,SB_TICKS))).
  - On the tick where the counter == OVERSAMPLE-1: clear the counter, clear the bit counter, go to DATA, set o_tx=shreg[0].
- DATA:
  - On the tick where the counter == OVERSAMPLE-1: shift right by 1 and clear the counter.
  - If the bit counter == DATA_BITS-1, go to STOP with o_tx=1 (or to PARITY without a feature-off path change; see Optional Feature).
  - Otherwise increment the bit counter and drive o_tx with the next bit.
- STOP:
  - o_tx=1.
  - On the tick where the counter == SB_TICKS-1: go to IDLE, pulse o_tx_done=1 for exactly one clk, deassert o_busy at the same edge.
- Ticks absent: all counters hold, and o_tx holds its value indefinitely.
- i_tx_start outside IDLE:
  - Ignored; not queued.
  - i_data changes after acceptance have no effect on the frame.
- Back-to-back:
  - i_tx_start held high through the done cycle is accepted at the next edge (state is IDLE then).
  - Minimum gap between frames: zero idle bit-times beyond the stop bit, plus one clk.
- Frame length in ticks: OVERSAMPLE*(1+DATA_BITS[+1 parity]) + SB_TICKS.
  - With i_baud_rate held high and defaults: o_tx_done is asserted 160 clks after the accept edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - After the last data bit, go to PARITY, driving o_tx = even parity (XOR of the captured byte).
  - The parity bit lasts OVERSAMPLE ticks; then go to STOP.
  - Parity is computed from the byte latched at acceptance.
  - Default frame becomes 176 clks with ticks held high.
- Undefined:
  - PARITY state and parity logic are absent; DATA goes directly to STOP.

Test Plan:
- Reset: rst=0 for 2 clks with i_tx_start=1 -> o_tx=1, o_busy=0, o_tx_done=0 throughout; no frame starts.
- Single frame (i_baud_rate held 1, feature off): i_data=0xA5, i_tx_start pulsed 1 clk.
  - o_tx sequence, 16 clks per level: 0 | 1,0,1,0,0,1,0,1 | 1.
  - o_tx_done one-clk pulse at 160 clks after the accept edge; o_busy high for exactly 160 clks.
- Sparse ticks (i_baud_rate=1 every 4th clk), i_data=0x00 -> each bit spans 64 clks; done after 640 clks; o_tx stays stable between ticks.
- Start while busy: i_data=0x3C accepted, then i_tx_start=1 with i_data=0xFF mid-DATA -> line carries only 0x3C (0,0,0,1,1,1,1,0,0 LSB first after start, stop 1); single done pulse.
- Reset mid-frame: assert rst=0 during DATA bit 3 -> next edge o_tx=1, o_busy=0, no o_tx_done; a new request after release sends a full correct frame.
- Parity (UART_TX_PARITY_EN defined): i_data=0x07 -> parity bit 1 for 16 clks between bit 7 and stop; done at 176 clks. i_data=0x03 -> parity bit 0.
